// File: rtl/conv_pkg.sv
// Shared definitions for the convolution path: pixel type and the flat
// tile element index used by both the loader and the convolution stage.
package conv_pkg;

  localparam int PIX_W = 32;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int tile_idx(input int col, input int row, input int w);
    return col + row * w;
  endfunction

endpackage

// File: rtl/tile_bank.sv
// One tile worth of pixel storage: single write port, whole tile visible
// on a flat read port so the convolution stage sees every element at once.
module tile_bank
  import conv_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int PIX_W = conv_pkg::PIX_W,
  parameter int IDX_W = 7
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [PIX_W-1:0]             data,
  output logic [DEPTH-1:0][PIX_W-1:0]  q
);

  // Data is intentionally not reset; validity is tracked by the loader.
  logic [PIX_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[idx] <= data;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_read
      assign q[gi] = mem_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/tile_loader.sv
// Assembles a row-major pixel stream into complete WIDTH_IN x WIDTH_IN tiles
// using two ping-pong banks, with SOF-based resync of partial tiles.
module tile_loader
  import conv_pkg::*;
#(
  parameter int WIDTH_IN = 10,
  parameter int PIX_W    = conv_pkg::PIX_W
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     pix_in_valid,
  output logic                                     pix_in_ready,
  input  logic [PIX_W-1:0]                         pix_in_data,
  input  logic                                     pix_in_sof,
  output logic                                     tile_valid,
  input  logic                                     tile_ready,
  output logic [WIDTH_IN*WIDTH_IN-1:0][PIX_W-1:0]  tile_out,
  output logic                                     sof_err
);

  localparam int TILE_N = WIDTH_IN * WIDTH_IN;
  localparam int IDX_W  = $clog2(TILE_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_N - 1);

  logic [IDX_W-1:0] wr_idx_reg, wr_idx_next, bank_idx;
  logic [1:0]       full_reg, full_next;
  logic             wr_bank_reg, rd_bank_reg, sof_err_reg;
  logic             accept, resync, last_beat, rd_fire;
  logic [TILE_N-1:0][PIX_W-1:0] bank_q [2];

  assign pix_in_ready = reset_n && !full_reg[wr_bank_reg];
  assign accept       = pix_in_valid && pix_in_ready;
  assign resync       = accept && pix_in_sof && (wr_idx_reg != '0);
  assign last_beat    = accept && !resync && (wr_idx_reg == LAST_IDX);
  assign rd_fire      = tile_valid && tile_ready;
  // A premature SOF restarts the tile in place rather than switching banks.
  assign bank_idx     = resync ? '0 : wr_idx_reg;

  always_comb begin
    full_next   = full_reg;
    wr_idx_next = wr_idx_reg;
    if (rd_fire) begin
      full_next[rd_bank_reg] = 1'b0;
    end
    if (last_beat) begin
      full_next[wr_bank_reg] = 1'b1;
    end
    if (resync) begin
      wr_idx_next = IDX_W'(1);
    end else if (last_beat) begin
      wr_idx_next = '0;
    end else if (accept) begin
      wr_idx_next = wr_idx_reg + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_reg    <= '0;
      wr_idx_reg  <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      sof_err_reg <= 1'b0;
    end else begin
      full_reg    <= full_next;
      wr_idx_reg  <= wr_idx_next;
      sof_err_reg <= resync;
      if (last_beat) begin
        wr_bank_reg <= !wr_bank_reg;
      end
      if (rd_fire) begin
        rd_bank_reg <= !rd_bank_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      tile_bank #(
        .DEPTH (TILE_N),
        .PIX_W (PIX_W),
        .IDX_W (IDX_W)
      ) u_bank (
        .clk  (clk),
        .we   (accept && (wr_bank_reg == 1'(gi))),
        .idx  (bank_idx),
        .data (pix_in_data),
        .q    (bank_q[gi])
      );
    end
  endgenerate

  assign tile_valid = full_reg[rd_bank_reg];
  assign tile_out   = bank_q[rd_bank_reg];
  assign sof_err    = sof_err_reg;

endmodule

// File: tb/tb_tile_loader.sv
// Scoreboard bench for tile_loader with 4x4 tiles: completed tiles are queued
// as they are streamed in and compared element by element at each handshake.
module tb_tile_loader;

  localparam int WIDTH_IN = 4;
  localparam int N        = WIDTH_IN * WIDTH_IN;

  typedef logic [N-1:0][31:0] tile_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_in_valid = 1'b0;
  logic        pix_in_sof = 1'b0;
  logic        tile_ready = 1'b0;
  logic [31:0] pix_in_data = '0;
  logic        pix_in_ready, tile_valid, sof_err;
  tile_t       tile_out;

  always #5 clk = ~clk;

  tile_loader #(
    .WIDTH_IN (WIDTH_IN),
    .PIX_W    (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_in_valid (pix_in_valid),
    .pix_in_ready (pix_in_ready),
    .pix_in_data  (pix_in_data),
    .pix_in_sof   (pix_in_sof),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .tile_out     (tile_out),
    .sof_err      (sof_err)
  );

  int    total = 0;
  int    bad = 0;
  int    handshakes = 0;
  tile_t sb[$];
  tile_t build;
  int    m_idx = 0;
  logic  exp_sof_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, update the model with
  // whatever handshakes the coming edge will perform.
  task automatic step(input logic v, input logic [31:0] d, input logic s,
                      input logic tr, input logic rn, output logic acc);
    logic  rd;
    tile_t t;
    @(negedge clk);
    check("tile_valid", 32'(tile_valid), 32'(sb.size() > 0));
    check("pix_in_ready", 32'(pix_in_ready), 32'(reset_n && (sb.size() < 2)));
    check("sof_err", 32'(sof_err), 32'(exp_sof_err));
    reset_n      = rn;
    pix_in_valid = v;
    pix_in_data  = d;
    pix_in_sof   = s;
    tile_ready   = tr;
    exp_sof_err  = 1'b0;
    acc = 1'b0;
    if (!rn) begin
      sb.delete();
      m_idx = 0;
      return;
    end
    acc = pix_in_valid && pix_in_ready;
    rd  = tile_valid && tile_ready;
    if (rd) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        t = sb.pop_front();
        for (int i = 0; i < N; i++) begin
          check($sformatf("tile_out[%0d]", i), tile_out[i], t[i]);
        end
        handshakes++;
        $display("tile handshake %0d: tile_out[0]=%0d tile_out[%0d]=%0d",
                 handshakes, tile_out[0], N - 1, tile_out[N-1]);
      end
    end
    if (acc) begin
      if (s && m_idx != 0) begin
        build[0]    = d;
        m_idx       = 1;
        exp_sof_err = 1'b1;
      end else begin
        build[m_idx] = d;
        if (m_idx == N - 1) begin
          sb.push_back(build);
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic idle(input logic tr);
    logic acc;
    step(1'b0, 32'd0, 1'b0, tr, 1'b1, acc);
  endtask

  task automatic send_pixel(input logic [31:0] d, input logic s, input logic tr,
                            output int tries);
    logic acc;
    tries = 0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, d, s, tr, 1'b1, acc);
      tries++;
      if (acc) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      idle(1'b1);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    logic acc;
    for (int k = 0; k < cycles; k++) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, acc);
    end
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    idle(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   tries;
    int   hs0;
    logic acc;

    do_reset(3);

    // Single tile held without consumer
    for (int i = 0; i < N; i++) send_pixel(32'(i), i == 0, 1'b0, tries);
    for (int k = 0; k < 10; k++) begin
      idle(1'b0);
      check("hold_tile_out[5]", tile_out[5], 32'd5);
      check("hold_tile_out[15]", tile_out[15], 32'd15);
    end
    drain();

    // Both banks fill, then one handshake releases backpressure
    for (int i = 0; i < 2 * N; i++) send_pixel(32'(i), (i % N) == 0, 1'b0, tries);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'd32, 1'b1, 1'b0, 1'b1, acc);
      check("bp_stall", 32'(acc), 32'd0);
    end
    step(1'b1, 32'd32, 1'b1, 1'b1, 1'b1, acc);
    check("bp_stall_on_release", 32'(acc), 32'd0);
    send_pixel(32'd32, 1'b1, 1'b0, tries);
    check("bp_ready_return_tries", 32'(tries), 32'd1);
    check("next_tile_out[0]", tile_out[0], 32'd16);
    for (int i = 33; i < 40; i++) send_pixel(32'(i), 1'b0, 1'b0, tries);

    // Reset mid-tile discards the held tile and the partial one
    do_reset(2);

    // Continuous streaming with a consumer always ready
    hs0 = handshakes;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < N; j++) begin
        send_pixel(32'(16 * k + j), j == 0, 1'b1, tries);
        check("continuous_no_stall", 32'(tries), 32'd1);
      end
    end
    drain();
    check("continuous_handshakes", 32'(handshakes - hs0), 32'd8);

    // Premature SOF at pixel 7 restarts the tile
    for (int i = 0; i < 7; i++) send_pixel(32'(100 + i), i == 0, 1'b0, tries);
    send_pixel(32'd107, 1'b1, 1'b0, tries);
    for (int i = 8; i < 23; i++) send_pixel(32'(100 + i), 1'b0, 1'b0, tries);
    idle(1'b0);
    check("resync_tile_out[0]", tile_out[0], 32'd107);
    drain();

    // Last-pixel write coincides with a read handshake
    hs0 = handshakes;
    for (int i = 0; i < N; i++) send_pixel(32'(200 + i), i == 0, 1'b0, tries);
    for (int i = 0; i < N - 1; i++) send_pixel(32'(216 + i), i == 0, 1'b0, tries);
    send_pixel(32'd231, 1'b0, 1'b1, tries);
    check("simul_tries", 32'(tries), 32'd1);
    idle(1'b0);
    check("simul_second_tile", tile_out[0], 32'd216);
    drain();
    check("simul_handshakes", 32'(handshakes - hs0), 32'd2);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
